// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing the vga_adapter write port among NUM_CLIENTS pixel drawers.
// Optional clipping of out-of-screen pixels is enabled by defining VGA_ARB_CLIP_EN.
module vga_draw_arbiter #(
    parameter int unsigned NUM_CLIENTS = 3,
    parameter int unsigned X_WIDTH     = 8,
    parameter int unsigned Y_WIDTH     = 7,
    parameter int unsigned COLOR_WIDTH = 3,
    parameter int unsigned X_LIMIT     = 160,
    parameter int unsigned Y_LIMIT     = 120
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CLIENTS-1:0]             req,
    input  logic [NUM_CLIENTS-1:0]             done,
    input  logic [NUM_CLIENTS-1:0]             pix_valid,
    input  logic [NUM_CLIENTS*X_WIDTH-1:0]     x_in,
    input  logic [NUM_CLIENTS*Y_WIDTH-1:0]     y_in,
    input  logic [NUM_CLIENTS*COLOR_WIDTH-1:0] color_in,
    output logic [NUM_CLIENTS-1:0]             grant,
    output logic [X_WIDTH-1:0]                 x,
    output logic [Y_WIDTH-1:0]                 y,
    output logic [COLOR_WIDTH-1:0]             color,
    output logic                               plot,
    output logic                               busy
);

    localparam int unsigned IDX_W = $clog2(NUM_CLIENTS);

`ifdef VGA_ARB_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        RELEASE
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_CLIENTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic                     plot_q, plot_d;
    logic [X_WIDTH-1:0]       x_q, x_d;
    logic [Y_WIDTH-1:0]       y_q, y_d;
    logic [COLOR_WIDTH-1:0]   color_q, color_d;

    logic [X_WIDTH-1:0]       sel_x;
    logic [Y_WIDTH-1:0]       sel_y;
    logic [COLOR_WIDTH-1:0]   sel_color;
    logic                     in_bounds;
    logic                     pix_ok;
    logic                     found;
    logic [IDX_W-1:0]         pick;
    int unsigned              cand;

    // In OWN the one-hot grant always matches last_q, so last_q doubles as the owner index.
    assign sel_x     = x_in[last_q*X_WIDTH +: X_WIDTH];
    assign sel_y     = y_in[last_q*Y_WIDTH +: Y_WIDTH];
    assign sel_color = color_in[last_q*COLOR_WIDTH +: COLOR_WIDTH];
    assign in_bounds = (32'(sel_x) < X_LIMIT) && (32'(sel_y) < Y_LIMIT);
    assign pix_ok    = !CLIP_EN || in_bounds;

    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = 0;
        for (int unsigned off = 1; off <= NUM_CLIENTS; off++) begin
            cand = (32'(last_q) + off) % NUM_CLIENTS;
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        plot_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << pick;
                    last_d  = pick;
                    state_d = OWN;
                end
            end
            OWN: begin
                // A pixel arriving alongside done is still written.
                if (grant_q[last_q] && pix_valid[last_q] && pix_ok) begin
                    plot_d  = 1'b1;
                    x_d     = sel_x;
                    y_d     = sel_y;
                    color_d = sel_color;
                end
                if (done[last_q] || !req[last_q]) begin
                    grant_d = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_CLIENTS - 1);
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            plot_q  <= plot_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
        end
    end

    assign grant = grant_q;
    assign plot  = plot_q;
    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
    assign busy  = |grant_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench for vga_draw_arbiter: expected pixels are queued when driven and
// popped by a monitor whenever plot is seen.
module tb_vga_draw_arbiter;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

`ifdef VGA_ARB_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req, done, pix_valid;
    logic [N*XW-1:0] x_in;
    logic [N*YW-1:0] y_in;
    logic [N*CW-1:0] color_in;
    logic [N-1:0]    grant;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   color;
    logic            plot, busy;

    int total = 0;
    int bad = 0;
    int plots_seen = 0;
    bit saw_5050 = 1'b0;
    logic [XW+YW+CW-1:0] exp_q[$];
    logic [XW+YW+CW-1:0] mon_e;

    always #5 clock = ~clock;

    vga_draw_arbiter #(
        .NUM_CLIENTS(N), .X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_WIDTH(CW),
        .X_LIMIT(160), .Y_LIMIT(120)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .done(done), .pix_valid(pix_valid),
        .x_in(x_in), .y_in(y_in), .color_in(color_in), .grant(grant),
        .x(x), .y(y), .color(color), .plot(plot), .busy(busy)
    );

    always @(negedge clock) begin
        if (plot === 1'b1) begin
            plots_seen++;
            if (x == 8'd50 && y == 7'd50) saw_5050 = 1'b1;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, required no plot", x, y, color);
            end else begin
                mon_e = exp_q.pop_front();
                if ({x, y, color} !== mon_e) begin
                    bad++;
                    $display("FAIL plot_data: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                             x, y, color, mon_e[XW+YW+CW-1 -: XW], mon_e[YW+CW-1 -: YW], mon_e[CW-1:0]);
                end
            end
        end
    end

    task automatic set_pix(input int c, input logic [XW-1:0] px, input logic [YW-1:0] py,
                           input logic [CW-1:0] pc, input bit expect_plot);
        pix_valid[c] = 1'b1;
        x_in[c*XW +: XW] = px;
        y_in[c*YW +: YW] = py;
        color_in[c*CW +: CW] = pc;
        if (expect_plot) exp_q.push_back({px, py, pc});
    endtask

    task automatic clear_inputs();
        req = '0;
        done = '0;
        pix_valid = '0;
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (grant == '0 && cyc < 20);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        clear_inputs();
        x_in = '0; y_in = '0; color_in = '0;
        reset = 1'b0;
        @(negedge clock);
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant: got %b, required 000", grant); end
        total++; if (plot !== 1'b0) begin bad++; $display("FAIL reset_plot: got %b, required 0", plot); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
        total++; if ({x, y, color} !== '0) begin bad++; $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d, required 0", x, y, color); end
        reset = 1'b1;
        @(negedge clock);
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL idle_no_req: got %b, required 000", grant); end
    endtask

    task automatic test_single_burst();
        int cyc;
        int p0;
        p0 = plots_seen;
        req = 3'b001;
        wait_grant(cyc);
        total++; if (cyc != 1) begin bad++; $display("FAIL grant_latency: got %0d, required 1", cyc); end
        total++; if (grant !== 3'b001) begin bad++; $display("FAIL single_grant: got %b, required 001", grant); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b, required 1", busy); end
        set_pix(0, 8'd10, 7'd20, 3'b100, 1'b1);
        @(negedge clock);
        set_pix(0, 8'd11, 7'd20, 3'b100, 1'b1);
        @(negedge clock);
        pix_valid = '0;
        done[0] = 1'b1;
        @(negedge clock);
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL single_release: got %b, required 000", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall: got %b, required 0", busy); end
        clear_inputs();
        @(negedge clock);
        total++; if (plots_seen - p0 != 2) begin bad++; $display("FAIL single_plot_count: got %0d, required 2", plots_seen - p0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_round_robin();
        int cyc;
        int idx;
        logic [N-1:0] exp_g [4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        do_reset();
        req = 3'b111;
        wait_grant(cyc);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                total++; if (cyc != 2) begin bad++; $display("FAIL rr_gap%0d: got %0d, required 2", k, cyc); end
            end
            total++; if (grant !== exp_g[k]) begin bad++; $display("FAIL rr_grant%0d: got %b, required %b", k, grant, exp_g[k]); end
            idx = (exp_g[k] == 3'b001) ? 0 : (exp_g[k] == 3'b010) ? 1 : 2;
            set_pix(idx, 8'(k * 3 + 1), 7'(k + 2), 3'(k + 1), 1'b1);
            @(negedge clock);
            pix_valid = '0;
            done[idx] = 1'b1;
            @(negedge clock);
            done = '0;
            total++; if (grant !== 3'b000) begin bad++; $display("FAIL rr_release%0d: got %b, required 000", k, grant); end
            if (k < 3) wait_grant(cyc);
        end
        clear_inputs();
        @(negedge clock);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rr_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_foreign_pixel();
        int cyc;
        do_reset();
        saw_5050 = 1'b0;
        req = 3'b100;
        wait_grant(cyc);
        total++; if (grant !== 3'b100) begin bad++; $display("FAIL foreign_grant: got %b, required 100", grant); end
        set_pix(1, 8'd50, 7'd50, 3'b001, 1'b0);
        done[1] = 1'b1;
        @(negedge clock);
        done = '0;
        total++; if (grant !== 3'b100) begin bad++; $display("FAIL foreign_done_ignored: got %b, required 100", grant); end
        set_pix(2, 8'd7, 7'd8, 3'b010, 1'b1);
        @(negedge clock);
        set_pix(2, 8'd9, 7'd8, 3'b101, 1'b1);
        @(negedge clock);
        pix_valid = '0;
        done[2] = 1'b1;
        @(negedge clock);
        clear_inputs();
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL foreign_release: got %b, required 000", grant); end
        @(negedge clock);
        total++; if (saw_5050) begin bad++; $display("FAIL foreign_leak: got plot of (50,50), required none"); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL foreign_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_done_with_pixel();
        int cyc;
        do_reset();
        req = 3'b001;
        wait_grant(cyc);
        set_pix(0, 8'd159, 7'd119, 3'b111, 1'b1);
        done[0] = 1'b1;
        @(negedge clock);
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL donepix_grant: got %b, required 000", grant); end
        total++; if (plot !== 1'b1) begin bad++; $display("FAIL donepix_plot: got %b, required 1", plot); end
        total++; if ({x, y, color} !== {8'd159, 7'd119, 3'd7}) begin bad++; $display("FAIL donepix_data: got x=%0d y=%0d c=%0d, required 159 119 7", x, y, color); end
        clear_inputs();
        @(negedge clock);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL donepix_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_clip();
        int cyc;
        int p0;
        int want;
        do_reset();
        p0 = plots_seen;
        want = CLIP ? 1 : 3;
        req = 3'b001;
        wait_grant(cyc);
        set_pix(0, 8'd160, 7'd5, 3'b001, !CLIP);
        @(negedge clock);
        set_pix(0, 8'd5, 7'd120, 3'b010, !CLIP);
        @(negedge clock);
        set_pix(0, 8'd159, 7'd119, 3'b011, 1'b1);
        @(negedge clock);
        pix_valid = '0;
        total++; if (grant !== 3'b001) begin bad++; $display("FAIL clip_burst_continues: got %b, required 001", grant); end
        done[0] = 1'b1;
        @(negedge clock);
        clear_inputs();
        @(negedge clock);
        total++; if (plots_seen - p0 != want) begin bad++; $display("FAIL clip_plot_count: got %0d, required %0d", plots_seen - p0, want); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL clip_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        req = 3'b001;
        wait_grant(cyc);
        total++; if (grant !== 3'b001) begin bad++; $display("FAIL midrst_grant: got %b, required 001", grant); end
        set_pix(0, 8'd20, 7'd30, 3'b110, 1'b1);
        @(negedge clock);
        set_pix(0, 8'd21, 7'd30, 3'b110, 1'b0);
        #2 reset = 1'b0;
        #1;
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL midrst_async_grant: got %b, required 000", grant); end
        total++; if (plot !== 1'b0) begin bad++; $display("FAIL midrst_async_plot: got %b, required 0", plot); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_async_busy: got %b, required 0", busy); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++; if (grant !== 3'b001) begin bad++; $display("FAIL midrst_regrant: got %b, required 001", grant); end
        total++; if (plot !== 1'b0) begin bad++; $display("FAIL midrst_no_partial: got %b, required 0", plot); end
        pix_valid = '0;
        done[0] = 1'b1;
        @(negedge clock);
        clear_inputs();
        @(negedge clock);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL midrst_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_foreign_pixel();
        test_done_with_pixel();
        test_clip();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
